// File: rtl/idct_block_writer.sv
// idct_block_writer: drains one 8x8 block of signed 32-bit IDCT results from
// the result RAM. Each sample is descaled, clipped to 8 bits and packed in
// even/odd pairs. The 32 resulting words are written into the Y, U or V
// plane of external SRAM.
// Optional feature: define IDCT_WRITER_CLIP_STATS_EN to count the saturated
// samples of the last block on clip_count. When it is undefined, clip_count
// is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; validates the request, latches base
// S_LI   | address 0 presented, read pipeline priming
// S_EVEN | even-column sample arrives, latched as high byte
// S_ODD  | odd-column sample arrives, pair is written to SRAM
// S_LO   | last word on the bus, done follows
module idct_block_writer #(
   parameter int          SHIFT     = 16,
   parameter logic [17:0] Y_BASE    = 18'd0,
   parameter logic [17:0] U_BASE    = 18'd38400,
   parameter logic [17:0] V_BASE    = 18'd57600,
   parameter int          Y_STRIDE  = 160,
   parameter int          UV_STRIDE = 80
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        start,
   input  logic [1:0]  plane,
   input  logic [4:0]  block_row,
   input  logic [5:0]  block_col,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [5:0]  dp_address,
   input  logic [31:0] dp_read_data,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic [6:0]  clip_count
);

   typedef enum logic [2:0] {S_IDLE, S_LI, S_EVEN, S_ODD, S_LO} state_t;

   state_t        state, state_next;
   logic          accept, reject, start_ok, last_word;
   logic [4:0]    word_cnt;
   logic [17:0]   cur_addr, stride_wrap;
   logic [17:0]   plane_base, row_step, base;
   logic [7:0]    even_pix, pixel;
   logic signed [31:0] v;
   logic          is_neg, is_high;

   // Request check: legal plane, row inside the image, column inside the plane
   assign start_ok = (plane != 2'd3) && (block_row <= 5'd29) &&
                     (block_col <= ((plane == 2'd0) ? 6'd39 : 6'd19));
   assign last_word = (word_cnt == 5'd31);
   assign busy      = (state != S_IDLE);

   // Block origin within the selected plane
   always_comb begin
      plane_base = Y_BASE;
      row_step   = 18'(8 * Y_STRIDE);
      case (plane)
         2'd1: begin
            plane_base = U_BASE;
            row_step   = 18'(8 * UV_STRIDE);
         end
         2'd2: begin
            plane_base = V_BASE;
            row_step   = 18'(8 * UV_STRIDE);
         end
         default: begin
            plane_base = Y_BASE;
            row_step   = 18'(8 * Y_STRIDE);
         end
      endcase
      base = plane_base + 18'(block_row) * row_step + 18'(block_col) * 18'd4;
   end

   // Descale and saturate the sample that is currently on the read port
   assign v       = $signed(dp_read_data) >>> SHIFT;
   assign is_neg  = v[31];
   assign is_high = !v[31] && (v[30:8] != 23'd0);
   assign pixel   = is_neg ? 8'd0 : (is_high ? 8'hFF : v[7:0]);

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= S_IDLE;
      else         state <= state_next;
   end

   // Next-state logic and start qualification
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reject     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (start_ok) begin
                  accept     = 1'b1;
                  state_next = S_LI;
               end else begin
                  reject     = 1'b1;
               end
            end
         end
         S_LI:    state_next = S_EVEN;
         S_EVEN:  state_next = S_ODD;
         S_ODD:   state_next = last_word ? S_LO : S_EVEN;
         S_LO:    state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Read addressing, pixel pairing and SRAM write port
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         done            <= 1'b0;
         err             <= 1'b0;
         dp_address      <= 6'd0;
         SRAM_address    <= 18'd0;
         SRAM_write_data <= 16'd0;
         SRAM_we_n       <= 1'b1;
         word_cnt        <= 5'd0;
         cur_addr        <= 18'd0;
         stride_wrap     <= 18'd0;
         even_pix        <= 8'd0;
      end else begin
         err       <= reject;
         done      <= (state == S_LO);
         SRAM_we_n <= (state != S_ODD);
         if (accept) begin
            cur_addr    <= base;
            stride_wrap <= (plane == 2'd0) ? 18'(Y_STRIDE - 3) : 18'(UV_STRIDE - 3);
            word_cnt    <= 5'd0;
            dp_address  <= 6'd0;
         end
         if (state == S_LI || state == S_EVEN)
            dp_address <= dp_address + 6'd1;
         if (state == S_EVEN)
            even_pix <= pixel;
         if (state == S_ODD) begin
            SRAM_address    <= cur_addr;
            SRAM_write_data <= {even_pix, pixel};
            word_cnt        <= word_cnt + 5'd1;
            // after the fourth word of a row, jump to the next image row
            cur_addr        <= (word_cnt[1:0] == 2'd3) ? cur_addr + stride_wrap
                                                       : cur_addr + 18'd1;
            dp_address      <= last_word ? 6'd0 : dp_address + 6'd1;
         end
      end
   end

`ifdef IDCT_WRITER_CLIP_STATS_EN
   logic sample_clipped;
   assign sample_clipped = is_neg | is_high;

   // Saturation count for the current block, held until the next start
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         clip_count <= 7'd0;
      else if (accept)
         clip_count <= 7'd0;
      else if ((state == S_EVEN || state == S_ODD) && sample_clipped)
         clip_count <= clip_count + 7'd1;
   end
`else
   assign clip_count = 7'd0;
`endif

endmodule
